// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing_gen to the game plane and VGA connector.
// Colour lanes exist only when the VGA_RGB_BLANK_EN macro is defined.
interface vga_timing_if;
    logic [10:0] h_coord;
    logic [9:0]  v_coord;
    logic        hsync;
    logic        vsync;
    logic        display_on;
    logic        frame_start;
`ifdef VGA_RGB_BLANK_EN
    logic [3:0]  red_in;
    logic [3:0]  green_in;
    logic [3:0]  blue_in;
    logic [3:0]  red_out;
    logic [3:0]  green_out;
    logic [3:0]  blue_out;
`endif

    modport master (
        output h_coord, v_coord, hsync, vsync, display_on, frame_start
`ifdef VGA_RGB_BLANK_EN
        , input red_in, green_in, blue_in
        , output red_out, green_out, blue_out
`endif
    );

    modport slave (
        input h_coord, v_coord, hsync, vsync, display_on, frame_start
`ifdef VGA_RGB_BLANK_EN
        , output red_in, green_in, blue_in
        , input red_out, green_out, blue_out
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 800x600@56Hz raster timing: per-axis ACTIVE/FRONT/SYNC/BACK FSMs with registered,
// zero-skew outputs. Define VGA_RGB_BLANK_EN for registered colour blanking.
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 72,
    parameter int H_BP     = 128,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 22,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic         pixel_clk,
    input  logic         rst_n,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE - 1);
    localparam logic [10:0] H_FP_END   = 11'(H_ACTIVE + H_FP - 1);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  V_FP_END   = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

    if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_size_check
        $error("vga_timing_gen: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_region_check
        $error("vga_timing_gen: every timing region must be at least 1");
    end

    typedef enum logic [1:0] {ST_ACTIVE, ST_FRONT, ST_SYNC, ST_BACK} axis_state_e;

    logic [10:0] r_h;
    logic [9:0]  r_v;
    axis_state_e r_h_state, r_v_state;
    logic        r_hsync, r_vsync, r_display_on, r_frame_start;

    logic [10:0] w_h_nxt;
    logic [9:0]  w_v_nxt;
    axis_state_e w_h_state_nxt, w_v_state_nxt;
    logic        w_h_wrap;
    logic        w_hsync_nxt, w_vsync_nxt, w_display_on_nxt, w_frame_start_nxt;

    // Outputs are decoded from the next state/counters so the registered flags
    // land on the same edge as the coordinates they describe.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_h_wrap      = (r_h == H_LAST);
        w_h_nxt       = w_h_wrap ? 11'd0 : r_h + 11'd1;
        w_v_nxt       = r_v;
        w_h_state_nxt = r_h_state;
        w_v_state_nxt = r_v_state;

        if (w_h_wrap) begin
            w_v_nxt = (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
        end

        case (r_h_state)
            ST_ACTIVE: if (r_h == H_ACT_END)  w_h_state_nxt = ST_FRONT;
            ST_FRONT:  if (r_h == H_FP_END)   w_h_state_nxt = ST_SYNC;
            ST_SYNC:   if (r_h == H_SYNC_END) w_h_state_nxt = ST_BACK;
            default:   if (w_h_wrap)          w_h_state_nxt = ST_ACTIVE;
        endcase

        if (w_h_wrap) begin
            case (r_v_state)
                ST_ACTIVE: if (r_v == V_ACT_END)  w_v_state_nxt = ST_FRONT;
                ST_FRONT:  if (r_v == V_FP_END)   w_v_state_nxt = ST_SYNC;
                ST_SYNC:   if (r_v == V_SYNC_END) w_v_state_nxt = ST_BACK;
                default:   if (r_v == V_LAST)     w_v_state_nxt = ST_ACTIVE;
            endcase
        end

        w_hsync_nxt       = (w_h_state_nxt == ST_SYNC) ? SYNC_POL : !SYNC_POL;
        w_vsync_nxt       = (w_v_state_nxt == ST_SYNC) ? SYNC_POL : !SYNC_POL;
        w_display_on_nxt  = (w_h_state_nxt == ST_ACTIVE) && (w_v_state_nxt == ST_ACTIVE);
        w_frame_start_nxt = (w_h_nxt == 11'd0) && (w_v_nxt == 10'd0);
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h           <= H_LAST;
            r_v           <= V_LAST;
            r_h_state     <= ST_BACK;
            r_v_state     <= ST_BACK;
            r_hsync       <= !SYNC_POL;
            r_vsync       <= !SYNC_POL;
            r_display_on  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_h_state     <= w_h_state_nxt;
            r_v_state     <= w_v_state_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_display_on  <= w_display_on_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    assign vga.h_coord     = r_h;
    assign vga.v_coord     = r_v;
    assign vga.display_on  = r_display_on;
    assign vga.frame_start = r_frame_start;

`ifdef VGA_RGB_BLANK_EN
    logic       r_hsync_d, r_vsync_d;
    logic [3:0] r_red, r_green, r_blue;

    // Colour arrives with the pixel currently on h/v_coord; syncs are delayed to match.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync_d <= !SYNC_POL;
            r_vsync_d <= !SYNC_POL;
            r_red     <= 4'h0;
            r_green   <= 4'h0;
            r_blue    <= 4'h0;
        end else begin
            r_hsync_d <= r_hsync;
            r_vsync_d <= r_vsync;
            r_red     <= r_display_on ? vga.red_in   : 4'h0;
            r_green   <= r_display_on ? vga.green_in : 4'h0;
            r_blue    <= r_display_on ? vga.blue_in  : 4'h0;
        end
    end

    assign vga.hsync     = r_hsync_d;
    assign vga.vsync     = r_vsync_d;
    assign vga.red_out   = r_red;
    assign vga.green_out = r_green;
    assign vga.blue_out  = r_blue;
`else
    assign vga.hsync = r_hsync;
    assign vga.vsync = r_vsync;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-geometry instance for line timing and a
// short-frame instance (10 lines) so whole-frame behaviour fits in a short run.
module tb_vga_timing_gen;
    localparam int H_TOTAL  = 1024;
    localparam int SV_TOTAL = 10;
    localparam int S_FRAME  = H_TOTAL * SV_TOTAL;
`ifdef VGA_RGB_BLANK_EN
    localparam int SKEW = 1;
`else
    localparam int SKEW = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_f;
    logic rst_n_s;
    int   total = 0;
    int   bad   = 0;
    int   k     = 0;

    vga_timing_if vf ();
    vga_timing_if vs ();

    vga_timing_gen u_full (
        .pixel_clk (clk),
        .rst_n     (rst_n_f),
        .vga       (vf)
    );

    vga_timing_gen #(
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (3)
    ) u_small (
        .pixel_clk (clk),
        .rst_n     (rst_n_s),
        .vga       (vs)
    );

    // Reference model: k counts cycles since reset release, k=0 being pixel (0,0).
    function automatic int eh(int kk);
        return kk % H_TOTAL;
    endfunction
    function automatic int ev_f(int kk);
        return (kk / H_TOTAL) % 625;
    endfunction
    function automatic int ev_s(int kk);
        return (kk / H_TOTAL) % SV_TOTAL;
    endfunction
    function automatic logic exp_hs(int kk);
        if (kk < 0) return 1'b0;
        return (eh(kk) >= 824) && (eh(kk) <= 895);
    endfunction
    function automatic logic exp_vs_s(int kk);
        if (kk < 0) return 1'b0;
        return (ev_s(kk) >= 5) && (ev_s(kk) <= 6);
    endfunction
    function automatic logic exp_de_f(int kk);
        return (eh(kk) < 800) && (ev_f(kk) < 600);
    endfunction
    function automatic logic exp_de_s(int kk);
        return (eh(kk) < 800) && (ev_s(kk) < 4);
    endfunction

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    task automatic test_reset();
        rst_n_f = 1'b0;
        rst_n_s = 1'b0;
        repeat (5) begin
            @(negedge clk);
            total++;
            if (vf.h_coord !== 11'd1023 || vf.v_coord !== 10'd624) begin
                bad++;
                $display("FAIL reset_coord_full got (%0d,%0d) want (1023,624)", vf.h_coord, vf.v_coord);
            end
            total++;
            if ({vf.hsync, vf.vsync, vf.display_on, vf.frame_start} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_flags_full got hs/vs/de/fs=%b want 0000",
                         {vf.hsync, vf.vsync, vf.display_on, vf.frame_start});
            end
            total++;
            if (vs.h_coord !== 11'd1023 || vs.v_coord !== 10'd9) begin
                bad++;
                $display("FAIL reset_coord_small got (%0d,%0d) want (1023,9)", vs.h_coord, vs.v_coord);
            end
        end
        rst_n_f = 1'b1;
        rst_n_s = 1'b1;
        k = -1;
        step();
        total++;
        if (vf.h_coord !== 11'd0 || vf.v_coord !== 10'd0 || vf.display_on !== 1'b1 ||
            vf.frame_start !== 1'b1 || vf.hsync !== 1'b0) begin
            bad++;
            $display("FAIL release_first got (%0d,%0d) de=%b fs=%b hs=%b want (0,0) de=1 fs=1 hs=0",
                     vf.h_coord, vf.v_coord, vf.display_on, vf.frame_start, vf.hsync);
        end
        total++;
        if (vs.h_coord !== 11'd0 || vs.v_coord !== 10'd0 || vs.frame_start !== 1'b1) begin
            bad++;
            $display("FAIL release_first_small got (%0d,%0d) fs=%b want (0,0) fs=1",
                     vs.h_coord, vs.v_coord, vs.frame_start);
        end
        step();
        total++;
        if (vf.h_coord !== 11'd1 || vf.v_coord !== 10'd0 || vf.frame_start !== 1'b0) begin
            bad++;
            $display("FAIL release_second got (%0d,%0d) fs=%b want (1,0) fs=0",
                     vf.h_coord, vf.v_coord, vf.frame_start);
        end
    endtask

    task automatic test_horizontal();
        int hs_cnt = 0;
        while (k < H_TOTAL) begin
            step();
            if (k < H_TOTAL && vf.hsync === 1'b1) hs_cnt++;
            total++;
            if (vf.h_coord !== 11'(eh(k)) || vf.v_coord !== 10'(ev_f(k))) begin
                bad++;
                $display("FAIL line_coord k=%0d got (%0d,%0d) want (%0d,%0d)",
                         k, vf.h_coord, vf.v_coord, eh(k), ev_f(k));
            end
            total++;
            if (vf.hsync !== exp_hs(k - SKEW)) begin
                bad++;
                $display("FAIL line_hsync k=%0d got %b want %b", k, vf.hsync, exp_hs(k - SKEW));
            end
            total++;
            if (vf.display_on !== exp_de_f(k)) begin
                bad++;
                $display("FAIL line_display_on k=%0d got %b want %b", k, vf.display_on, exp_de_f(k));
            end
        end
        total++;
        if (hs_cnt != 72) begin
            bad++;
            $display("FAIL line_hsync_width got %0d want 72", hs_cnt);
        end
        total++;
        if (vf.h_coord !== 11'd0 || vf.v_coord !== 10'd1) begin
            bad++;
            $display("FAIL line_wrap got (%0d,%0d) want (0,1)", vf.h_coord, vf.v_coord);
        end
    endtask

    task automatic test_vertical();
        int vs_cnt = 0;
        while (k < S_FRAME) begin
            step();
            if (k < S_FRAME && vs.vsync === 1'b1) vs_cnt++;
            total++;
            if (vs.h_coord !== 11'(eh(k)) || vs.v_coord !== 10'(ev_s(k))) begin
                bad++;
                $display("FAIL frame_coord k=%0d got (%0d,%0d) want (%0d,%0d)",
                         k, vs.h_coord, vs.v_coord, eh(k), ev_s(k));
            end
            total++;
            if (vs.vsync !== exp_vs_s(k - SKEW)) begin
                bad++;
                $display("FAIL frame_vsync k=%0d got %b want %b", k, vs.vsync, exp_vs_s(k - SKEW));
            end
            total++;
            if (vs.display_on !== exp_de_s(k) || vs.hsync !== exp_hs(k - SKEW)) begin
                bad++;
                $display("FAIL frame_de_hs k=%0d got de=%b hs=%b want de=%b hs=%b",
                         k, vs.display_on, vs.hsync, exp_de_s(k), exp_hs(k - SKEW));
            end
            total++;
            if (vs.frame_start !== (k % S_FRAME == 0) || vf.frame_start !== 1'b0) begin
                bad++;
                $display("FAIL frame_start k=%0d got small=%b full=%b want small=%b full=0",
                         k, vs.frame_start, vf.frame_start, (k % S_FRAME == 0));
            end
        end
        total++;
        if (vs_cnt != 2 * H_TOTAL) begin
            bad++;
            $display("FAIL frame_vsync_width got %0d want %0d", vs_cnt, 2 * H_TOTAL);
        end
    endtask

    task automatic test_frame_period();
        int   stop    = k + 3 * S_FRAME;
        int   n_fs    = 0;
        int   n_vs    = 0;
        int   n_fs_f  = 0;
        int   last    = 0;
        logic prev_vs = vs.vsync;
        while (k < stop) begin
            if (vs.frame_start === 1'b1) begin
                if (n_fs > 0) begin
                    total++;
                    if (k - last != S_FRAME) begin
                        bad++;
                        $display("FAIL period_spacing got %0d want %0d", k - last, S_FRAME);
                    end
                end
                n_fs++;
                last = k;
            end
            if (vf.frame_start === 1'b1) n_fs_f++;
            if (vs.vsync === 1'b1 && prev_vs === 1'b0) n_vs++;
            prev_vs = vs.vsync;
            step();
        end
        total++;
        if (n_fs != 3) begin
            bad++;
            $display("FAIL period_frame_start_count got %0d want 3", n_fs);
        end
        total++;
        if (n_vs != 3) begin
            bad++;
            $display("FAIL period_vsync_count got %0d want 3", n_vs);
        end
        total++;
        if (n_fs_f != 0) begin
            bad++;
            $display("FAIL period_full_no_frame_start got %0d want 0", n_fs_f);
        end
    endtask

    task automatic test_mid_reset();
        int target = k + 5 * H_TOTAL + 850;
        while (k < target) step();
        total++;
        if (vs.h_coord !== 11'd850 || vs.v_coord !== 10'd5 || vs.hsync !== 1'b1 || vs.vsync !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre got (%0d,%0d) hs=%b vs=%b want (850,5) hs=1 vs=1",
                     vs.h_coord, vs.v_coord, vs.hsync, vs.vsync);
        end
        #2 rst_n_s = 1'b0;
        #1;
        total++;
        if (vs.hsync !== 1'b0 || vs.vsync !== 1'b0 || vs.display_on !== 1'b0 || vs.frame_start !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async_flags got hs/vs/de/fs=%b want 0000",
                     {vs.hsync, vs.vsync, vs.display_on, vs.frame_start});
        end
        total++;
        if (vs.h_coord !== 11'd1023 || vs.v_coord !== 10'd9) begin
            bad++;
            $display("FAIL midrst_async_coord got (%0d,%0d) want (1023,9)", vs.h_coord, vs.v_coord);
        end
        repeat (3) step();
        rst_n_s = 1'b1;
        step();
        total++;
        if (vs.h_coord !== 11'd0 || vs.v_coord !== 10'd0 || vs.frame_start !== 1'b1 ||
            vs.display_on !== 1'b1 || vs.hsync !== 1'b0 || vs.vsync !== 1'b0) begin
            bad++;
            $display("FAIL midrst_restart got (%0d,%0d) fs=%b de=%b hs=%b vs=%b want (0,0) fs=1 de=1 hs=0 vs=0",
                     vs.h_coord, vs.v_coord, vs.frame_start, vs.display_on, vs.hsync, vs.vsync);
        end
        step();
        total++;
        if (vs.h_coord !== 11'd1 || vs.v_coord !== 10'd0 || vs.frame_start !== 1'b0) begin
            bad++;
            $display("FAIL midrst_second got (%0d,%0d) fs=%b want (1,0) fs=0",
                     vs.h_coord, vs.v_coord, vs.frame_start);
        end
    endtask

`ifdef VGA_RGB_BLANK_EN
    task automatic test_rgb_blank();
        int   stop = k + H_TOTAL;
        logic [3:0] want;
        while (k < stop) begin
            step();
            want = exp_de_f(k - 1) ? 4'hF : 4'h0;
            total++;
            if (vf.red_out !== want || vf.green_out !== want || vf.blue_out !== want) begin
                bad++;
                $display("FAIL rgb_blank k=%0d h=%0d got r/g/b=%h/%h/%h want %h",
                         k, eh(k), vf.red_out, vf.green_out, vf.blue_out, want);
            end
        end
    endtask
`endif

    initial begin
`ifdef VGA_RGB_BLANK_EN
        vf.red_in = 4'hF; vf.green_in = 4'hF; vf.blue_in = 4'hF;
        vs.red_in = 4'hF; vs.green_in = 4'hF; vs.blue_in = 4'hF;
`endif
        test_reset();
        test_horizontal();
        test_vertical();
        test_frame_period();
        test_mid_reset();
`ifdef VGA_RGB_BLANK_EN
        test_rgb_blank();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
